// File: rtl/dsc_mul_sched_if.sv
// Request/response bundle between client logic and the multiplier scheduler.
// master = client side, slave = scheduler side.
interface dsc_mul_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_z;
  logic [15:0]       rsp_cycles;
  logic              rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_cycles, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_z, rsp_cycles, rsp_err
  );
endinterface

// File: rtl/dsc_mul_sched.sv
// Round-robin scheduler sharing one serial stochastic multiplier; accept->rsp is 3+N_run cycles (1 on a zero operand).
// One operation in flight; req_ready is low while busy and the response is held until rsp_ready.
module dsc_mul_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int W       = 4,
  parameter int TIMEOUT = 300
) (
  input  logic           clk,
  input  logic           rst,
  dsc_mul_sched_if.slave bus,
  output logic           busy,
  output logic           mul_rst,
  output logic           mul_en,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_z,
  input  logic           mul_ov
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_CAPT, S_RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, id_q;
  logic [IDW-1:0] win, win_lo, win_hi;
  logic           win_vld, hi_vld;
  logic [W-1:0]   a_sel, b_sel, op_a, op_b;
  logic [15:0]    cnt, cnt_inc, cyc_q;
  logic [2*W-1:0] z_q;
  logic           err_q, accept, zero_op, run_to;

  // Winner is the lowest valid index above ptr, else the lowest valid index overall (wrap).
  always_comb begin
    win_lo  = '0;
    win_hi  = '0;
    win_vld = 1'b0;
    hi_vld  = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        win_lo  = IDW'(i);
        win_vld = 1'b1;
        if (IDW'(i) > ptr) begin
          win_hi = IDW'(i);
          hi_vld = 1'b1;
        end
      end
    end
    win = hi_vld ? win_hi : win_lo;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win) begin
        a_sel = bus.req_a[i*W +: W];
        b_sel = bus.req_b[i*W +: W];
      end
    end
  end

  assign accept  = (state == S_IDLE) && win_vld;
  assign zero_op = (a_sel == '0) || (b_sel == '0);
  assign cnt_inc = (&cnt) ? cnt : cnt + 16'd1;
  assign run_to  = (cnt_inc == 16'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    mul_rst       = 1'b1;
    mul_en        = 1'b0;
    busy          = (state != S_IDLE);
    bus.rsp_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = accept && (IDW'(i) == win);
    end
    case (state)
      S_IDLE: begin
        if (win_vld) state_nxt = zero_op ? S_RESP : S_CLR;
      end
      S_CLR: state_nxt = S_RUN;
      S_RUN: begin
        mul_rst = 1'b0;
        mul_en  = 1'b1;
        if (mul_ov)      state_nxt = S_CAPT;
        else if (run_to) state_nxt = S_RESP;
      end
      S_CAPT: begin
        mul_rst   = 1'b0;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= IDW'(NREQ - 1);
      id_q  <= '0;
      op_a  <= '0;
      op_b  <= '0;
      cnt   <= '0;
      cyc_q <= '0;
      z_q   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            ptr   <= win;
            id_q  <= win;
            op_a  <= a_sel;
            op_b  <= b_sel;
            cnt   <= '0;
            cyc_q <= '0;
            z_q   <= '0;
            err_q <= 1'b0;
          end
        end
        S_RUN: begin
          cnt <= cnt_inc;
          if (mul_ov) begin
            cyc_q <= cnt_inc;
          end else if (run_to) begin
            cyc_q <= cnt_inc;
            err_q <= 1'b1;
          end
        end
        // The core's product settles one cycle after ov.
        S_CAPT: z_q <= mul_z;
        default: ;
      endcase
    end
  end

  assign mul_a          = op_a;
  assign mul_b          = op_b;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_z      = z_q;
  assign bus.rsp_cycles = cyc_q;
  assign bus.rsp_err    = err_q;

endmodule
